dec_seq: RTL and testbench
==========================

# dec_seq

Registered, parametrised N-to-2^N one-hot decoder with enable, extending the lab-05 combinational 2x4 decoder with sequential output modes. It is used to drive one-hot select, strobe and scan lines (e.g. display digit select, row/column strobes) in later labs. It supports three modes: level decode, timed pulse and free-running scan. All outputs are registered.

## Interface
- `IN_W`, default 2: select width; output width is `OUT_W = 2**IN_W`; legal range 1..6.
- `PULSE_LEN`, default 4: pulse-mode high time in cycles; must be ≥ 1.
- `SCAN_DWELL`, default 1: cycles each output is held in scan mode; must be ≥ 1.

Ports:
- `clk`, input, 1: rising-edge clock, the only clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `en`, input, 1: global enable; low forces IDLE.
- `mode`, input, 2: 00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (treated as IDLE).
- `in`, input, IN_W: select value.
- `load`, input, 1: pulse trigger, sampled only in IDLE with mode 01.
- `dout`, output, OUT_W: one-hot or all-zero decode output.
- `idx`, output, IN_W: index of the currently asserted output; 0 when `dout` is 0.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation
- Four states: IDLE, LEVEL, PULSE, SCAN.
- Reset: state is IDLE; `dout` = 0, `idx` = 0, `busy` = 0; pulse and dwell counters are 0.
- Priority at each edge: `en`=0 wins. It sends the block to IDLE, clears `dout`, `idx` and the counters, and aborts any pulse or scan.
- From IDLE with `en`=1:
  - mode 00: go to LEVEL, `dout` = onehot(`in`).
  - mode 01 with `load`=1: go to PULSE, `dout` = onehot(`in`), pulse counter = PULSE_LEN-1.
  - mode 01 with `load`=0: stay in IDLE.
  - mode 10: go to SCAN, `dout` = onehot(0), `idx` = 0, dwell counter = SCAN_DWELL-1.
  - mode 11: stay in IDLE.
- LEVEL:
  - While mode stays 00, `dout` = onehot(`in`) every cycle.
  - Any other mode: go to IDLE, `dout` = 0.
- PULSE:
  - `in` is captured at trigger; later changes on `in` are ignored.
  - Pulse counter > 0: hold `dout` and decrement.
  - Pulse counter = 0: go to IDLE, `dout` = 0.
  - `load` while in PULSE is ignored (no retrigger, no queuing).
  - Mode change: abort to IDLE, `dout` = 0.
- SCAN:
  - Dwell counter > 0: hold `dout` and decrement.
  - Dwell counter = 0: `idx` = (`idx`+1) mod OUT_W, `dout` becomes onehot(new `idx`), dwell counter reloads to SCAN_DWELL-1.
  - Wrap from OUT_W-1 to 0 is seamless, with no zero cycle.
  - Mode change: go to IDLE, `dout` = 0.
- Every mode change out of a non-IDLE state passes through exactly one IDLE cycle with `dout` = 0 before the new mode starts.
- Invariant: `dout` is always all-zero or exactly one-hot, and `dout[idx]`=1 whenever `dout` ≠ 0.

## Timing
- `dout`, `idx` and `busy` are all registered, with no combinational path from inputs to outputs.
- LEVEL latency is 1 cycle: `in` sampled at edge t appears on `dout` after edge t.
- PULSE: `dout` is high for exactly PULSE_LEN cycles, starting the cycle after the edge that samples `load`.
  - Minimum spacing between triggers is PULSE_LEN+1 cycles, because IDLE must be observed for one cycle before the next `load`.
- SCAN: each output is high for SCAN_DWELL cycles; full period is OUT_W×SCAN_DWELL cycles.
- Asynchronous reset mid-operation clears all outputs immediately, without waiting for a clock edge.
- Deassertion of `rst_n` is assumed synchronised externally; the first active edge after release behaves as from IDLE.
- Counter widths: `$clog2(PULSE_LEN)` and `$clog2(SCAN_DWELL)` bits, minimum 1 bit each.

## Structure
- Package `dec_seq_pkg` holds:
  - the mode encodings `MODE_LEVEL`, `MODE_PULSE`, `MODE_SCAN`, `MODE_RSVD`;
  - the state enum `dec_state_t`.
- One sub-module, `onehot_dec`: combinational IN_W→OUT_W decoder with enable, instantiated once. It feeds the `dout` register from a mux of `in`, the captured select and `idx`.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
All scenarios use IN_W=2, PULSE_LEN=3, SCAN_DWELL=2.
- Reset and enable: assert `rst_n`=0 mid-scan → `dout`=0000, `idx`=0, `busy`=0 immediately. With `en`=0, walking `in` 0..3 in mode 00 → `dout` stays 0000.
- Level decode: `en`=1, mode 00, `in`=0,1,2,3 on successive cycles → `dout`=0001,0010,0100,1000, each one cycle later; `busy`=1.
- Pulse: mode 01, `in`=2, one-cycle `load` → `dout`=0100 for exactly 3 cycles, then 0000. A second `load` during the pulse is ignored. A `load` on the first IDLE cycle retriggers.
- Scan wrap: mode 10 held for 10 cycles → `dout` sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001,0001, with `idx` tracking.
- Abort and mode change: mid-pulse, switch mode to 00 with `in`=3 → one cycle `dout`=0000, then 1000. Mid-scan, drop `en` → `dout`=0000 next cycle; re-enabling restarts the scan at `idx`=0.
- Reserved mode: mode 11 with `en`=1 → state remains IDLE, `dout`=0000, `busy`=0.

Source files
------------

// File: rtl/dec_seq_pkg.sv
// dec_seq_pkg: shared mode encodings and FSM state type for the dec_seq
// registered one-hot decoder.
package dec_seq_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEVEL = 2'd1,
    ST_PULSE = 2'd2,
    ST_SCAN  = 2'd3
  } dec_state_t;

endpackage

// File: rtl/dec_seq_if.sv
// dec_seq_if: control inputs and decode outputs of dec_seq.
//   en, mode, in, load : driven by the controller (master)
//   dout, idx, busy    : driven by the decoder (slave)
interface dec_seq_if #(
  parameter int IN_W = 2
);
  import dec_seq_pkg::*;

  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic [1:0]       mode;
  logic [IN_W-1:0]  in;
  logic             load;
  logic [OUT_W-1:0] dout;
  logic [IN_W-1:0]  idx;
  logic             busy;

  modport master (output en, mode, in, load, input dout, idx, busy);
  modport slave  (input en, mode, in, load, output dout, idx, busy);

endinterface

// File: rtl/dec_seq_onehot.sv
// onehot_dec: combinational IN_W -> 2**IN_W one-hot decoder with enable.
//   sel : select value
//   en  : when low the output is all-zero
//   y   : one-hot (or zero) result
module onehot_dec #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  sel,
  input  logic             en,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_seq.sv
// dec_seq: registered one-hot decoder with level, timed-pulse and scan modes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dec_seq_if slave (en/mode/in/load in, dout/idx/busy out)
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | outputs zero, waiting for a mode to start
// ST_LEVEL | dout follows onehot(in) with one cycle latency
// ST_PULSE | dout holds captured select for PULSE_LEN cycles
// ST_SCAN  | dout walks through all outputs, SCAN_DWELL cycles each
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int PULSE_LEN  = 4,
  parameter int SCAN_DWELL = 1
) (
  input logic      clk,
  input logic      rst_n,
  dec_seq_if.slave bus
);

  localparam int OUT_W = 2 ** IN_W;
  localparam int PW    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int DW    = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam logic [PW-1:0] P_LOAD = PW'(PULSE_LEN - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(SCAN_DWELL - 1);

  if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
    $error("dec_seq: IN_W must be in 1..6");
  end
  if (PULSE_LEN < 1) begin : g_bad_pulse_len
    $error("dec_seq: PULSE_LEN must be >= 1");
  end
  if (SCAN_DWELL < 1) begin : g_bad_scan_dwell
    $error("dec_seq: SCAN_DWELL must be >= 1");
  end

  dec_state_t       state, state_nx;
  logic [IN_W-1:0]  idx_q, idx_nx;
  logic             on_nx;
  logic [PW-1:0]    pcnt_q, pcnt_nx;
  logic [DW-1:0]    dcnt_q, dcnt_nx;
  logic [OUT_W-1:0] dout_q, dec_y;

  // idx_nx doubles as the decoder select: it is `in` in LEVEL, the select
  // captured at trigger in PULSE (held in idx_q), and the scan position.
  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    on_nx    = 1'b0;
    pcnt_nx  = pcnt_q;
    dcnt_nx  = dcnt_q;

    if (!bus.en) begin
      state_nx = ST_IDLE;
      idx_nx   = '0;
      pcnt_nx  = '0;
      dcnt_nx  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_nx = '0;
          if (bus.mode == MODE_LEVEL) begin
            state_nx = ST_LEVEL;
            idx_nx   = bus.in;
            on_nx    = 1'b1;
          end else if (bus.mode == MODE_PULSE && bus.load) begin
            state_nx = ST_PULSE;
            idx_nx   = bus.in;
            on_nx    = 1'b1;
            pcnt_nx  = P_LOAD;
          end else if (bus.mode == MODE_SCAN) begin
            state_nx = ST_SCAN;
            on_nx    = 1'b1;
            dcnt_nx  = D_LOAD;
          end
        end
        ST_LEVEL: begin
          if (bus.mode == MODE_LEVEL) begin
            idx_nx = bus.in;
            on_nx  = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
          end
        end
        ST_PULSE: begin
          if (bus.mode != MODE_PULSE || pcnt_q == '0) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            pcnt_nx  = '0;
          end else begin
            on_nx   = 1'b1;
            pcnt_nx = pcnt_q - PW'(1);
          end
        end
        ST_SCAN: begin
          if (bus.mode != MODE_SCAN) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
            dcnt_nx  = '0;
          end else if (dcnt_q == '0) begin
            on_nx   = 1'b1;
            idx_nx  = idx_q + IN_W'(1);  // natural wrap gives mod OUT_W
            dcnt_nx = D_LOAD;
          end else begin
            on_nx   = 1'b1;
            dcnt_nx = dcnt_q - DW'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  onehot_dec #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dec (
    .sel (idx_nx),
    .en  (on_nx),
    .y   (dec_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      dout_q <= '0;
      idx_q  <= '0;
      pcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      state  <= state_nx;
      dout_q <= dec_y;
      idx_q  <= idx_nx;
      pcnt_q <= pcnt_nx;
      dcnt_q <= dcnt_nx;
    end
  end

  assign bus.dout = dout_q;
  assign bus.idx  = idx_q;
  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dec_seq.sv
module tb_dec_seq;
  import dec_seq_pkg::*;

  localparam int IN_W  = 2;
  localparam int PL    = 3;
  localparam int SD    = 2;
  localparam int OUT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_seq_if #(.IN_W(IN_W)) bus ();

  dec_seq #(.IN_W(IN_W), .PULSE_LEN(PL), .SCAN_DWELL(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which activity is running, how many edges since it
  // started, and the select it shows. act: 0 none, 1 level, 2 pulse, 3 scan.
  int         act = 0;
  int         n   = 0;
  logic [1:0] sel = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic e, input logic [1:0] m, input logic [1:0] i, input logic l);
    if (!e) begin
      act = 0;
    end else if (act == 0) begin
      if (m == 2'd0) begin act = 1; sel = i; end
      else if (m == 2'd1 && l) begin act = 2; sel = i; n = 0; end
      else if (m == 2'd2) begin act = 3; n = 0; end
    end else if (act == 1) begin
      if (m == 2'd0) sel = i;
      else act = 0;
    end else if (act == 2) begin
      if (m != 2'd1) act = 0;
      else begin
        n++;
        if (n >= PL) act = 0;
      end
    end else begin
      if (m != 2'd2) act = 0;
      else n++;
    end
  endtask

  task automatic check_model(input string tag);
    int ei;
    logic [31:0] ed;
    if (act == 0) ei = 0;
    else if (act == 3) ei = (n / SD) % OUT_W;
    else ei = int'(sel);
    ed = (act == 0) ? 32'd0 : (32'd1 << ei);
    chk({tag, "_dout"}, bus.dout, ed);
    chk({tag, "_idx"}, bus.idx, ei);
    chk({tag, "_busy"}, bus.busy, (act != 0));
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] m, input logic [1:0] i, input logic l);
    bus.en = e; bus.mode = m; bus.in = i; bus.load = l;
    @(posedge clk);
    model_edge(e, m, i, l);
    #1;
    check_model(tag);
  endtask

  logic [3:0] scan_seq [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
  logic [1:0] cur_mode;

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 2'd0; bus.in = '0; bus.load = 1'b0;
    #2;
    chk("reset_dout", bus.dout, 0);
    chk("reset_idx", bus.idx, 0);
    chk("reset_busy", bus.busy, 0);
    #10 rst_n = 1'b1;

    for (int k = 0; k < 4; k++) step("en_low_walk", 1'b0, 2'd0, 2'(k), 1'b0);

    for (int k = 0; k < 4; k++) begin
      step("level", 1'b1, 2'd0, 2'(k), 1'b0);
      chk("level_const", bus.dout, 32'd1 << k);
    end

    step("rsvd_exit", 1'b1, 2'd3, 2'd1, 1'b0);
    step("rsvd", 1'b1, 2'd3, 2'd1, 1'b1);
    chk("rsvd_busy", bus.busy, 0);
    step("rsvd2", 1'b1, 2'd3, 2'd2, 1'b0);

    step("pulse_trig", 1'b1, 2'd1, 2'd2, 1'b1);
    chk("pulse_first", bus.dout, 4'b0100);
    step("pulse_reload", 1'b1, 2'd1, 2'd1, 1'b1);
    step("pulse_hold", 1'b1, 2'd1, 2'd0, 1'b0);
    chk("pulse_last", bus.dout, 4'b0100);
    step("pulse_end", 1'b1, 2'd1, 2'd0, 1'b0);
    chk("pulse_end_const", bus.dout, 0);
    step("pulse_retrig", 1'b1, 2'd1, 2'd2, 1'b1);
    chk("pulse_retrig_const", bus.dout, 4'b0100);
    step("pulse_mid", 1'b1, 2'd1, 2'd3, 1'b0);
    step("abort_idle", 1'b1, 2'd0, 2'd3, 1'b0);
    chk("abort_zero", bus.dout, 0);
    step("abort_level", 1'b1, 2'd0, 2'd3, 1'b0);
    chk("abort_level_const", bus.dout, 4'b1000);

    step("scan_exit_level", 1'b1, 2'd2, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("scan", 1'b1, 2'd2, 2'd1, 1'b0);
      chk("scan_seq", bus.dout, scan_seq[k]);
    end

    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", bus.dout, 0);
    chk("async_rst_idx", bus.idx, 0);
    chk("async_rst_busy", bus.busy, 0);
    act = 0;
    #1 rst_n = 1'b1;

    for (int k = 0; k < 5; k++) step("scan2", 1'b1, 2'd2, 2'd0, 1'b0);
    step("scan_en_drop", 1'b0, 2'd2, 2'd0, 1'b0);
    chk("scan_en_drop_const", bus.dout, 0);
    step("scan_restart", 1'b1, 2'd2, 2'd0, 1'b0);
    chk("scan_restart_idx", bus.idx, 0);
    chk("scan_restart_dout", bus.dout, 4'b0001);

    cur_mode = 2'd0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(7) == 0) cur_mode = 2'($urandom_range(3));
      step("rand", ($urandom_range(15) != 0), cur_mode, 2'($urandom_range(3)),
           ($urandom_range(2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
